// File: rtl/pe_bus_streamer_if.sv
// Command, SRAM read port and PE broadcast bus of the streamer.
// master = streamer side, slave = environment (command source, SRAM, PEs).
interface pe_bus_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int NUM_CH     = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [NUM_CH-1:0]     cmd_mask;
  logic                  abort;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [NUM_CH-1:0]     pe_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]     out_en;
  logic                  busy;
  logic                  done;
  logic [LEN_WIDTH-1:0]  sent_cnt;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_mask, abort, mem_rd_data, pe_ready,
    output cmd_ready, mem_rd_en, mem_rd_addr, out_data, out_en, busy, done, sent_cnt
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_mask, abort, mem_rd_data, pe_ready,
    input  cmd_ready, mem_rd_en, mem_rd_addr, out_data, out_en, busy, done, sent_cnt
  );
endinterface

// File: rtl/pe_bus_streamer.sv
// Reads a block of words from a 1-cycle-latency SRAM and streams it over a shared
// bus to one or more PEs through a small skid buffer.
//
// Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready.
// A bus beat transfers on an edge where out_en[i] is high; out_en is only raised
// when every selected PE is ready, so a beat is never partially delivered.
module pe_bus_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  pe_bus_streamer_if.master      bus,
  output logic [1:0]             state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  len_q, issued, sent;
  logic [NUM_CH-1:0]     mask_q;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  inflight;
  logic                  done_q;

  logic                  active, all_rdy, pop, push, issue, last_pop, end_cmd, zero_cmd;
  logic [CW:0]           occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign active   = (state != IDLE);
  assign all_rdy  = &(bus.pe_ready | ~mask_q);
  assign pop      = active && (count != '0) && all_rdy;
  assign push     = active && inflight;
  // Occupancy the buffer will have once the in-flight word lands and this cycle's pop leaves.
  assign occ      = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue    = (state == RUN) && !bus.abort && (issued < len_q) &&
                    (occ < (CW+1)'(BUF_DEPTH));
  assign last_pop = pop && ((sent + LEN_WIDTH'(1)) == len_q);
  assign end_cmd  = active && (bus.abort || last_pop);
  assign zero_cmd = (bus.cmd_len == '0) || (bus.cmd_mask == '0);

  always_comb begin
    state_nxt     = state;
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid && !zero_cmd) state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (end_cmd)               state_nxt = IDLE;
        else if (issued == len_q)  state_nxt = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (end_cmd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_addr  <= '0;
      len_q    <= '0;
      mask_q   <= '0;
      issued   <= '0;
      sent     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      done_q   <= 1'b0;
      inflight <= issue;
      if (state == IDLE && bus.cmd_valid) begin
        rd_addr <= bus.cmd_addr;
        len_q   <= bus.cmd_len;
        mask_q  <= bus.cmd_mask;
        issued  <= '0;
        sent    <= '0;
        if (zero_cmd) done_q <= 1'b1;
      end
      if (issue) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
        issued  <= issued + LEN_WIDTH'(1);
      end
      if (push) begin
        buf_mem[wr_ptr] <= bus.mem_rd_data;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        sent   <= sent + LEN_WIDTH'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      // Abort (or natural end) discards anything buffered and the read still in flight.
      if (end_cmd) begin
        done_q   <= 1'b1;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
      end
    end
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.out_data    = buf_mem[rd_ptr];
  assign bus.out_en      = {NUM_CH{pop}} & mask_q;
  assign bus.done        = done_q;
  assign bus.sent_cnt    = sent;
  assign state_dbg       = state;
endmodule

// File: tb/tb_pe_bus_streamer.sv
// Directed bench for pe_bus_streamer: SRAM model mem[a]=a+1, expected-word queue
// filled at command time and drained by a negedge bus monitor.
module tb_pe_bus_streamer;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  pe_bus_streamer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8), .NUM_CH(4)) bus ();

  pe_bus_streamer #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8), .NUM_CH(4), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_beat_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int beats = 0;
  int rd_cnt = 0;
  bit chk_lat = 1'b0;
  bit chk_consec = 1'b0;
  bit stall_chk = 1'b0;
  logic [3:0]  exp_mask = '0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {8'h00, a} + 16'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial bus.mem_rd_data = '0;
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem_word(bus.mem_rd_addr);

  // Bus monitor: samples mid-cycle, pops the scoreboard on every beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (stall_chk && !(&(bus.pe_ready | ~exp_mask))) begin
        check("stall_no_en", 32'(bus.out_en), 32'h0);
        if (cyc >= accept_cyc + 3 && exp_q.size() > 0)
          check("stall_hold", 32'(bus.out_data), 32'(exp_q[0]));
      end
      if (|bus.out_en) begin
        check("out_en_mask", 32'(bus.out_en), 32'(exp_mask));
        if (exp_q.size() == 0) check("unexpected_beat", 32'(bus.out_data), 32'hFFFF_FFFF);
        else check("beat_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        if (chk_lat && beats == 0) check("first_beat_latency", 32'(cyc - accept_cyc), 32'd3);
        if (chk_consec && beats > 0) check("gapless", 32'(cyc - last_beat_cyc), 32'd1);
        beats++;
        last_beat_cyc = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [7:0] addr, input logic [7:0] len, input logic [3:0] mask);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_mask  = mask;
    bus.cmd_valid = 1'b1;
    exp_mask      = mask;
    beats         = 0;
    accept_cyc    = cyc;
    if (len != 0 && mask != 0)
      for (int i = 0; i < int'(len); i++) exp_q.push_back(mem_word(addr + 8'(i)));
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Wait for completion, then check a normal (non-aborted) command end.
  task automatic finish_cmd(input int len, input int d0, input int r0, input bit zero);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_cnt > d0), 32'd1);
    tick();
    tick();
    check("single_done", 32'(done_cnt - d0), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("beat_count", 32'(beats), 32'(zero ? 0 : len));
    check("sent_cnt", 32'(bus.sent_cnt), 32'(zero ? 0 : len));
    check("busy_after", 32'(bus.busy), 32'd0);
    check("cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
    if (zero) begin
      check("zero_done_cycle", 32'(done_cyc - accept_cyc), 32'd1);
      check("zero_no_reads", 32'(rd_cnt - r0), 32'd0);
    end else begin
      check("done_after_last", 32'(done_cyc - last_beat_cyc), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
    check({tag, "_out_en"}, 32'(bus.out_en), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_sent_cnt"}, 32'(bus.sent_cnt), 32'd0);
  endtask

  initial begin
    int d0, r0, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_mask  = '0;
    bus.abort     = 1'b0;
    bus.pe_ready  = 4'hF;
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // abort while idle does nothing
    d0 = done_cnt;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    tick();
    check("idle_abort_done", 32'(done_cnt - d0), 32'd0);
    check("idle_abort_ready", 32'(bus.cmd_ready), 32'd1);

    // unicast, latency and throughput
    d0 = done_cnt; r0 = rd_cnt;
    chk_lat = 1'b1; chk_consec = 1'b1;
    launch(8'h00, 8'd6, 4'b0001);
    check("rd_en_cycle1", 32'(bus.mem_rd_en), 32'd1);
    check("rd_addr_cycle1", 32'(bus.mem_rd_addr), 32'd0);
    check("busy_run", 32'(bus.busy), 32'd1);
    finish_cmd(6, d0, r0, 1'b0);

    // broadcast across the address wrap
    d0 = done_cnt; r0 = rd_cnt;
    launch(8'hFE, 8'd4, 4'b1111);
    finish_cmd(4, d0, r0, 1'b0);

    // multicast with PE2 stalling cycles 5..9, plus a command offered while busy
    d0 = done_cnt; r0 = rd_cnt;
    chk_lat = 1'b1; chk_consec = 1'b0; stall_chk = 1'b1;
    launch(8'h00, 8'd12, 4'b0101);
    n = 1;
    while (done_cnt == d0 && n < 100) begin
      n = cyc - accept_cyc;
      bus.pe_ready  = (n >= 5 && n <= 9) ? 4'b1011 : 4'hF;
      bus.cmd_valid = (n == 7);
      bus.cmd_len   = 8'd3;
      bus.cmd_mask  = 4'b1111;
      if (n == 7) check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.pe_ready  = 4'hF;
    stall_chk = 1'b0;
    finish_cmd(12, d0, r0, 1'b0);

    // zero-length and zero-mask commands
    chk_lat = 1'b0;
    d0 = done_cnt; r0 = rd_cnt;
    launch(8'h30, 8'd0, 4'b0011);
    finish_cmd(0, d0, r0, 1'b1);
    d0 = done_cnt; r0 = rd_cnt;
    launch(8'h30, 8'd5, 4'b0000);
    finish_cmd(0, d0, r0, 1'b1);

    // abort after the 7th beat
    d0 = done_cnt;
    launch(8'h00, 8'd20, 4'b0001);
    n = 0;
    while (beats < 7 && n < 100) begin
      tick();
      n++;
    end
    check("abort_reach_7", 32'(beats), 32'd7);
    bus.pe_ready = 4'h0;
    bus.abort    = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.pe_ready = 4'hF;
    check("abort_done", 32'(bus.done), 32'd1);
    check("abort_sent_cnt", 32'(bus.sent_cnt), 32'd7);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    check("abort_single_done", 32'(done_cnt - d0), 32'd1);
    check("abort_no_stale", 32'(beats), 32'd7);
    exp_q.delete();
    d0 = done_cnt; r0 = rd_cnt;
    chk_consec = 1'b1;
    launch(8'h10, 8'd2, 4'b0001);
    finish_cmd(2, d0, r0, 1'b0);

    // synchronous reset mid-RUN
    d0 = done_cnt;
    launch(8'h40, 8'd10, 4'b0011);
    n = 0;
    while (beats < 3 && n < 100) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (3) tick();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt; r0 = rd_cnt;
    chk_lat = 1'b1;
    launch(8'h20, 8'd3, 4'b0010);
    finish_cmd(3, d0, r0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_bus_streamer.md
Name: pe_bus_streamer

Overview:
- Synthesizable, parametrised successor to the fmap/weight bus driver used in PE benches.
- Accepts a command (base address, length, channel mask) and reads 16-bit words from a local buffer SRAM with 1-cycle read latency.
- Streams those words over one shared data bus to NUM_CH PEs, using each PE's not-full ready (!fifo_full_*).
- Supports unicast and multicast. A multicast beat transfers only when every selected PE is ready.

Parameters:
DATA_WIDTH, 16, bus/SRAM word width
ADDR_WIDTH, 8, SRAM address width; addresses wrap modulo 2^ADDR_WIDTH
LEN_WIDTH, 8, command length field width
NUM_CH, 4, number of PE channels driven
BUF_DEPTH, 2, skid buffer entries; minimum 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  streamer can accept a command
cmd_addr  in  ADDR_WIDTH  first SRAM address
cmd_len  in  LEN_WIDTH  words to send
cmd_mask  in  NUM_CH  destination channels
abort  in  1  synchronous cancel of the current command
mem_rd_en  out  1  SRAM read strobe
mem_rd_addr  out  ADDR_WIDTH  SRAM read address
mem_rd_data  in  DATA_WIDTH  SRAM data, valid the cycle after mem_rd_en
pe_ready  in  NUM_CH  per-PE ready (=!fifo_full)
out_data  out  DATA_WIDTH  shared bus data
out_en  out  NUM_CH  per-PE write enable (feature_in_en/weight_in_en)
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes or is aborted
sent_cnt  out  LEN_WIDTH  words transferred in the current/last command

Behaviour:
- Single clock. Reset is synchronous and active-high: on rst at a posedge, all state clears, including the FSM, counters, skid buffer and in-flight flag.
- Reset values: cmd_ready=1, busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, out_en=0, out_data=0, sent_cnt=0.
- FSM states IDLE, RUN, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid the command is latched, sent_cnt clears, and the FSM moves to RUN.
  - If cmd_len=0 or cmd_mask=0: the FSM goes straight back to IDLE and done pulses the next cycle. No reads, no out_en.
- RUN:
  - cmd_ready=0, busy=1.
  - Read issue: mem_rd_en=1 when issued < len and (occupancy + inflight − pop) < BUF_DEPTH.
  - mem_rd_addr increments after each issue and wraps 0xFF→0x00.
  - When issued == len, the FSM moves to DRAIN.
- Capture: mem_rd_data is written into the skid buffer the cycle after mem_rd_en. The FIFO order of the buffer is the address order.
- Output:
  - out_data = buffer head. It is held stable while stalled.
  - all_rdy = &(pe_ready | ~mask).
  - pop = buffer non-empty & all_rdy.
  - out_en[i] = pop & mask[i]. A PE samples out_data in the same cycle.
  - sent_cnt increments on each pop.
- DRAIN: pops continue. When the last word pops (sent_cnt reaches len), the FSM goes to IDLE and done=1 in the following cycle. busy drops together with done.
- Latency: command accepted in cycle 0 → mem_rd_en in cycle 1 → earliest out_en in cycle 3.
- Throughput: 1 word/cycle sustained while all_rdy stays high.
- Backpressure:
  - When any masked PE is not ready, there is no out_en on any channel. Non-masked channels never see out_en.
  - Issue stalls when the buffer would overflow. No data is lost or duplicated.
- Boundary conditions:
  - A pe_ready toggle on the same cycle is honoured combinationally.
  - A full buffer with a simultaneous pop allows an issue.
  - cmd_valid during RUN/DRAIN is ignored (cmd_ready=0).
  - abort in RUN/DRAIN:
    - The buffer is flushed and the in-flight read is discarded.
    - The FSM goes to IDLE and done pulses the next cycle.
    - sent_cnt keeps the count of words actually transferred.
  - abort in IDLE has no effect.
  - abort and the final pop in the same cycle: the pop counts and a single done pulse is issued.
  - rst mid-operation returns to the reset values on the next edge and issues no done.

Test Plan:
- SRAM mem[a]=a+1, cmd addr=0 len=6 mask=0001, pe_ready=1 → out_en[0] high on 6 consecutive cycles starting cycle 3, data 1..6. done is one pulse after the last beat and sent_cnt=6.
- addr=0xFE len=4 mask=1111 → data 0xFF,0x100,1,2 (wrap to address 0) broadcast on all four out_en.
- len=12 mask=0101, pe_ready[2] low for cycles 5–9 → no out_en on any channel in those cycles, out_data frozen, data 1..12 in order with no gaps or duplicates. out_en[1] and out_en[3] stay 0 throughout.
- len=0 (and separately mask=0) → done one cycle after accept, mem_rd_en never asserts.
- len=20, abort after the 7th beat → done pulses, sent_cnt=7, cmd_ready=1. A next command len=2 addr=0x10 outputs 0x11,0x12 only, with no stale data.
- rst held one cycle mid-RUN → all outputs at reset values next cycle, no done pulse, and a new command runs normally.
